spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Single-byte SPI master controller, mode 0 (CPOL=0, CPHA=0).
- Accepts a byte from the system controller via a START/BUSY/DONE handshake, then drives CS_N, SCLK and MOSI, and samples MISO.
- Internally it sequences a transmit shift register (load, shift, bit count) and a receive shift register.
- Sits between the system controller and the external SPI pins, replacing direct TE/WRITE gating of the sender path.

Parameters:
- CLK_DIV, 4, CLK cycles per SCLK half-period; legal range 1..255.
- DATA_W, 8, bits per transfer; legal range 2..16.
- CS_IDLE_CYCLES, 2, minimum CLK cycles CS_N stays high between transfers; legal range 1..255.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- CLR  input  1  synchronous active-high reset.
- START  input  1  request a transfer; sampled only while BUSY=0.
- TX_DATA  input  DATA_W  byte to send; captured in the cycle START is accepted.
- MISO  input  1  serial data from slave.
- BUSY  output  1  high from the cycle after START is accepted until the controller returns to IDLE.
- DONE  output  1  one-cycle pulse when RX_DATA becomes valid.
- RX_DATA  output  DATA_W  received word; held until the next DONE.
- SCLK  output  1  SPI clock, idle low.
- MOSI  output  1  serial data to slave.
- CS_N  output  1  active-low chip select.

Behaviour:
- Reset (CLR=1 at a CLK edge, from any state, mid-transfer included):
  - State goes to IDLE.
  - Outputs: CS_N=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0.
  - Divider counter and bit counter are cleared.
  - Any partial transfer is discarded; no DONE is generated.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - START=1 → latch TX_DATA into the tx shifter and go to SETUP.
  - Next cycle: BUSY=1, CS_N=0, MOSI=TX_DATA[DATA_W-1].
- SETUP:
  - Lasts CLK_DIV cycles with SCLK=0, then go to SHIFT.
- SHIFT:
  - The divider toggles SCLK every CLK_DIV cycles, giving DATA_W rising and DATA_W falling edges (2*DATA_W*CLK_DIV cycles total).
  - In the cycle SCLK goes 0→1: shift MISO into the LSB of the rx shifter.
  - In the cycle SCLK goes 1→0: the tx shifter shifts left and MOSI presents the next bit, except after the final falling edge.
  - The bit counter counts falling edges, DATA_W-1 down to 0.
  - After the last falling edge (SCLK=0), go to HOLD.
- HOLD:
  - Lasts CLK_DIV cycles; CS_N=0, SCLK=0, MOSI holds the last bit.
  - Exit → GAP.
- GAP:
  - First cycle: CS_N=1, MOSI=0, DONE=1, RX_DATA updated with the rx shifter.
  - Lasts CS_IDLE_CYCLES cycles, then go to IDLE with BUSY=0 in the next cycle.
- Timing, START accepted at cycle 0:
  - BUSY high cycles 1 .. 18*CLK_DIV+CS_IDLE_CYCLES (DATA_W=8).
  - DONE at cycle 1+(2*DATA_W+2)*CLK_DIV.
- START while BUSY=1 is ignored: not queued, TX_DATA not sampled.
- START held high continuously → back-to-back transfers, each separated by exactly CS_IDLE_CYCLES+1 cycles of CS_N=1. The +1 is the IDLE accept cycle.
- TX_DATA changes after acceptance have no effect on the current transfer.
- SCLK never glitches: it is registered and toggles only in SHIFT.
- Counters do not wrap: the divider reloads at CLK_DIV-1; the bit counter is width clog2(DATA_W).
- Simultaneous CLR and START: CLR wins.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined:
  - The tx shifter shifts right, so MOSI starts at TX_DATA[0].
  - The rx shifter shifts MISO into the MSB, so the first received bit lands in RX_DATA[0].
- Undefined: MSB-first, as described in Behaviour.
- Timing is identical in both builds.

Test Plan:
1. Reset values: CLR=1 for 3 cycles → CS_N=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0x00.
2. Single transfer:
   - Stimulus: CLK_DIV=2, CS_IDLE_CYCLES=2, TX_DATA=0xA5, START pulse at cycle 0, MISO loopback from MOSI.
   - Required: MOSI bits 1,0,1,0,0,1,0,1 sampled on SCLK rising edges; 8 SCLK pulses; DONE at cycle 37; RX_DATA=0xA5; BUSY low from cycle 39.
3. Slave model returns 0x3C while TX_DATA=0xFF → RX_DATA=0x3C at DONE; MOSI constant 1 during SHIFT.
4. START reasserted at cycle 10 of a transfer → ignored; exactly one DONE; CS_N stays low continuously until the GAP state.
5. CLR at cycle 15 mid-SHIFT → next cycle CS_N=1, SCLK=0, BUSY=0; no DONE; then a fresh START with 0x5A completes with RX_DATA=0x5A (loopback).
6. START held high, TX_DATA 0x01 then 0x80 → two DONEs; CS_N high for exactly 3 cycles between the transfers. With SPI_LSB_FIRST_EN defined, the first MOSI bit of 0x01 is 1.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// Single-word SPI mode-0 master with a START/BUSY/DONE handshake and registered pin outputs.
// Build option: define SPI_LSB_FIRST_EN to shift LSB-first (default build is MSB-first).
module spi_master_ctrl #(
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned CS_IDLE_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              START,
   input  logic [DATA_W-1:0] TX_DATA,
   input  logic              MISO,
   output logic              BUSY,
   output logic              DONE,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              SCLK,
   output logic              MOSI,
   output logic              CS_N
);

   // One counter serves both the SCLK divider and the CS_N idle gap; both limits fit in 8 bits.
   localparam int unsigned      CNT_W    = 8;
   localparam int unsigned      BIT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_IDLE_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [BIT_W-1:0]  bit_q;
   logic [DATA_W-1:0] tx_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              busy_q, done_q, sclk_q, mosi_q, cs_n_q;

   logic              load_bit, next_bit;
   logic [DATA_W-1:0] tx_shift, rx_shift;

   // The tx shifter rotates rather than zero-fills; the wrapped bit is never presented.
   always_comb begin
`ifdef SPI_LSB_FIRST_EN
      load_bit = TX_DATA[0];
      tx_shift = {tx_q[0], tx_q[DATA_W-1:1]};
      next_bit = tx_q[1];
      rx_shift = {MISO, rx_q[DATA_W-1:1]};
`else
      load_bit = TX_DATA[DATA_W-1];
      tx_shift = {tx_q[DATA_W-2:0], tx_q[DATA_W-1]};
      next_bit = tx_q[DATA_W-2];
      rx_shift = {rx_q[DATA_W-2:0], MISO};
`endif
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  state_q <= StSetup;
                  cnt_q   <= DIV_LAST;
                  bit_q   <= BIT_LAST;
                  tx_q    <= TX_DATA;
                  busy_q  <= 1'b1;
                  cs_n_q  <= 1'b0;
                  mosi_q  <= load_bit;
               end
            end
            StSetup: begin
               if (cnt_q == '0) begin
                  state_q <= StShift;
                  cnt_q   <= DIV_LAST;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StShift: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  cnt_q  <= DIV_LAST;
                  sclk_q <= ~sclk_q;
                  if (!sclk_q) begin
                     rx_q <= rx_shift;
                  end else if (bit_q == '0) begin
                     // Final falling edge: MOSI keeps the last bit through HOLD.
                     state_q <= StHold;
                  end else begin
                     tx_q   <= tx_shift;
                     mosi_q <= next_bit;
                     bit_q  <= bit_q - 1'b1;
                  end
               end
            end
            StHold: begin
               if (cnt_q == '0) begin
                  state_q   <= StGap;
                  cnt_q     <= GAP_LAST;
                  cs_n_q    <= 1'b1;
                  mosi_q    <= 1'b0;
                  done_q    <= 1'b1;
                  rx_data_q <= rx_q;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StGap: begin
               if (cnt_q == '0) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign RX_DATA = rx_data_q;
   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign CS_N    = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: stimulus pushes expected transfers, a negedge monitor
// pops and checks them on DONE; a simple mode-0 slave model or MOSI loopback drives MISO.
module tb_spi_master_ctrl;

   localparam int unsigned CD  = 2;
   localparam int unsigned DW  = 8;
   localparam int unsigned CSI = 2;
   // Cycle offsets from the START-accept cycle.
   localparam int unsigned DONE_LAT     = 1 + (2 * DW + 2) * CD;
   localparam int unsigned BUSY_LOW_LAT = (2 * DW + 2) * CD + CSI + 1;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       START = 1'b0;
   logic [7:0] TX_DATA = 8'h00;
   logic       MISO;
   logic       BUSY, DONE, SCLK, MOSI, CS_N;
   logic [7:0] RX_DATA;

   spi_master_ctrl #(
      .CLK_DIV        (CD),
      .DATA_W         (DW),
      .CS_IDLE_CYCLES (CSI)
   ) dut (
      .CLK     (CLK),
      .CLR     (CLR),
      .START   (START),
      .TX_DATA (TX_DATA),
      .MISO    (MISO),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .RX_DATA (RX_DATA),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .CS_N    (CS_N)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Order of bits on the wire, first-sent bit placed in the MSB of the result.
   function automatic logic [7:0] wire_order(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
`ifdef SPI_LSB_FIRST_EN
         r[7-i] = w[i];
`else
         r[7-i] = w[7-i];
`endif
      end
      return r;
   endfunction

   typedef struct {
      logic [7:0]  tx;
      logic [7:0]  rx;
      int unsigned acc;
   } exp_t;

   exp_t sb[$];

   // Slave model: presents its word in wire order, advancing after each SCLK falling edge.
   bit         loopback = 1'b1;
   logic [7:0] slave_word = 8'h00;
   logic [7:0] slave_seq;
   int         slave_idx = 0;
   logic       s_pcs = 1'b1, s_psc = 1'b0;

   assign slave_seq = wire_order(slave_word);
   assign MISO      = loopback ? MOSI : slave_seq[7-slave_idx];

   initial forever begin
      @(negedge CLK);
      if (s_pcs && !CS_N) slave_idx = 0;
      else if (s_psc && !SCLK && slave_idx < 7) slave_idx++;
      s_pcs = CS_N;
      s_psc = SCLK;
   end

   // Monitor
   logic        m_psclk = 1'b0, m_pbusy = 1'b0;
   logic [7:0]  mosi_seq = 8'h00;
   int          pulses = 0, cs_glitch = 0;
   bit          in_xfer = 1'b0, await_busy = 1'b0;
   int unsigned last_acc = 0;

   initial forever begin
      @(negedge CLK);
      if (CLR) begin
         in_xfer    = 1'b0;
         await_busy = 1'b0;
      end else begin
         if (BUSY && !m_pbusy) begin
            in_xfer   = 1'b1;
            mosi_seq  = 8'h00;
            pulses    = 0;
            cs_glitch = 0;
         end
         if (in_xfer && SCLK && !m_psclk) begin
            mosi_seq = {mosi_seq[6:0], MOSI};
            pulses++;
         end
         if (in_xfer && !DONE && CS_N) cs_glitch++;
         if (DONE) begin
            check("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("rx_data", RX_DATA, e.rx);
               check("done_cycle", cyc, e.acc + DONE_LAT);
               check("mosi_bits", mosi_seq, wire_order(e.tx));
               check("sclk_pulses", pulses, DW);
               check("cs_n_low_span", cs_glitch, 0);
               last_acc   = e.acc;
               await_busy = 1'b1;
            end
            in_xfer = 1'b0;
         end
         if (!BUSY && m_pbusy && await_busy) begin
            check("busy_fall_cycle", cyc, last_acc + BUSY_LOW_LAT);
            await_busy = 1'b0;
         end
      end
      m_psclk = SCLK;
      m_pbusy = BUSY;
   end

   // Stimulus helpers; all called at posedge+#1.
   task automatic start_xfer(input logic [7:0] tx, input bit loop, input logic [7:0] sw,
                             output int unsigned acc);
      int n = 0;
      while (BUSY !== 1'b0 && n < 200) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check("idle_before_start", BUSY, 0);
      loopback   = loop;
      slave_word = sw;
      TX_DATA    = tx;
      START      = 1'b1;
      acc        = cyc;
      sb.push_back('{tx, loop ? tx : sw, cyc});
      @(posedge CLK);
      #1;
      START   = 1'b0;
      TX_DATA = 8'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || BUSY !== 1'b0) && n < 400) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check("drained", 32'(sb.size() == 0 && BUSY === 1'b0), 1);
   endtask

   task automatic until_cycle(input int unsigned c);
      while (cyc < c) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned acc, c2;
      int          cnt, dones;

      // Reset with START asserted: CLR must win.
      CLR     = 1'b1;
      START   = 1'b1;
      TX_DATA = 8'hFF;
      repeat (3) @(posedge CLK);
      #1;
      START = 1'b0;
      check("rst_cs_n", CS_N, 1);
      check("rst_sclk", SCLK, 0);
      check("rst_mosi", MOSI, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_rx_data", RX_DATA, 8'h00);
      CLR = 1'b0;
      @(posedge CLK);
      #1;

      // Single loopback transfer.
      start_xfer(8'hA5, 1'b1, 8'h00, acc);
      wait_drain();

      // Slave returns 0x3C while sending 0xFF.
      start_xfer(8'hFF, 1'b0, 8'h3C, acc);
      wait_drain();

      // START during BUSY is ignored.
      start_xfer(8'h96, 1'b1, 8'h00, acc);
      until_cycle(acc + 10);
      START   = 1'b1;
      TX_DATA = 8'h11;
      @(posedge CLK);
      #1;
      START = 1'b0;
      wait_drain();

      // CLR mid-SHIFT discards the transfer.
      start_xfer(8'hC3, 1'b1, 8'h00, acc);
      until_cycle(acc + 15);
      CLR = 1'b1;
      sb.delete();
      @(posedge CLK);
      #1;
      CLR = 1'b0;
      check("clr_cs_n", CS_N, 1);
      check("clr_sclk", SCLK, 0);
      check("clr_busy", BUSY, 0);
      dones = 0;
      repeat (60) begin
         if (DONE) dones++;
         @(posedge CLK);
         #1;
      end
      check("clr_no_done", dones, 0);
      start_xfer(8'h5A, 1'b1, 8'h00, acc);
      wait_drain();

      // START held high: back-to-back transfers.
      loopback = 1'b1;
      TX_DATA  = 8'h01;
      START    = 1'b1;
      acc      = cyc;
      c2       = acc + BUSY_LOW_LAT;
      sb.push_back('{8'h01, 8'h01, acc});
      sb.push_back('{8'h80, 8'h80, c2});
      @(posedge CLK);
      #1;
      TX_DATA = 8'h80;
      cnt     = 0;
      while (cyc <= c2 + 1) begin
         if (CS_N) cnt++;
         @(posedge CLK);
         #1;
      end
      check("b2b_cs_high_cycles", cnt, CSI + 1);
      until_cycle(c2 + 5);
      START = 1'b0;
      wait_drain();

      // Randomized transfers, some with a stray START while busy.
      for (int i = 0; i < 12; i++) begin
         int unsigned r;
         repeat ($urandom_range(0, 3)) begin
            @(posedge CLK);
            #1;
         end
         start_xfer(8'($urandom), 1'($urandom), 8'($urandom), acc);
         if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(2, 30);
            until_cycle(acc + r);
            START   = 1'b1;
            TX_DATA = 8'($urandom);
            @(posedge CLK);
            #1;
            START = 1'b0;
         end
      end
      wait_drain();
      repeat (4) @(posedge CLK);
      #1;
      check("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
